// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: FSM states, fetch length and byte-lane helpers shared by the
// memory controller and the load/store buffer.
package mem_ctrl_pkg;
  typedef enum logic [1:0] {MC_IDLE, MC_IF_RD, MC_LS_RD, MC_LS_WR} mc_state_e;
  localparam logic [2:0] IF_LEN = 3'd4;
  function automatic logic is_io(input logic [31:0] a);
    return a[17:16] == 2'b11;
  endfunction
  function automatic logic [2:0] dec_len(input logic [2:0] l);
    return (l == 3'd1 || l == 3'd2) ? l : 3'd4;
  endfunction
  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i, input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[8*i +: 8] = b;
    return r;
  endfunction
  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] i);
    return w[8*i +: 8];
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM/IO bus controller serving the load/store buffer
// and instruction fetch, little-endian assembly, 1-cycle done pulses.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        lsb_en,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [2:0]  lsb_len,
  input  logic [31:0] lsb_w_data,
  output logic        lsb_done,
  output logic [31:0] lsb_r_data,
  input  logic        if_en,
  input  logic [31:0] if_pc,
  output logic        if_done,
  output logic [31:0] if_data
);
  mc_state_e   state, state_n;
  logic [2:0]  cnt, cnt_n, len, len_n;
  logic [31:0] addr, addr_n, wdata, wdata_n, a_n, lsb_r_n, if_data_n;
  logic [7:0]  dout_n;
  logic        wr_q, wr_n, lsb_done_n, if_done_n, if_prio, if_prio_n;
  logic        take_ls, accept;
  assign mem_wr  = wr_q && rdy && !(io_buffer_full && is_io(mem_a));
  // a fetch that waited behind one LSB op wins the next arbitration
  assign take_ls = lsb_en && !(if_prio && if_en);
  assign accept  = rdy && !rollback && !lsb_done && !if_done && (lsb_en || if_en);
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    len_n      = len;
    addr_n     = addr;
    wdata_n    = wdata;
    a_n        = mem_a;
    dout_n     = mem_dout;
    wr_n       = wr_q;
    lsb_done_n = 1'b0;
    if_done_n  = 1'b0;
    lsb_r_n    = lsb_r_data;
    if_data_n  = if_data;
    if_prio_n  = if_prio;
    if (rdy) begin
      if (state == MC_IDLE) begin
        if (accept) begin
          state_n   = take_ls ? (lsb_wr ? MC_LS_WR : MC_LS_RD) : MC_IF_RD;
          addr_n    = take_ls ? lsb_addr : if_pc;
          len_n     = take_ls ? dec_len(lsb_len) : IF_LEN;
          wdata_n   = lsb_w_data;
          a_n       = addr_n;
          dout_n    = lsb_w_data[7:0];
          wr_n      = take_ls && lsb_wr;
          cnt_n     = 3'd0;
          if_prio_n = take_ls && if_en;
          lsb_r_n   = (take_ls && !lsb_wr) ? 32'd0 : lsb_r_data;
        end
      end else if (state == MC_LS_WR) begin
        if (mem_wr) begin
          cnt_n = cnt + 3'd1;
          if (cnt_n < len) begin
            a_n    = addr + {29'd0, cnt_n};
            dout_n = get_byte(wdata, cnt_n[1:0]);
          end else begin
            state_n    = MC_IDLE;
            wr_n       = 1'b0;
            lsb_done_n = 1'b1;
          end
        end
      end else if (rollback) begin
        state_n = MC_IDLE;
      end else if (cnt == len) begin
        state_n    = MC_IDLE;
        lsb_done_n = state == MC_LS_RD;
        if_done_n  = state == MC_IF_RD;
      end else begin
        // mem_din holds the byte for addr+cnt driven in the previous cycle
        lsb_r_n   = (state == MC_LS_RD) ? put_byte(lsb_r_data, cnt[1:0], mem_din) : lsb_r_data;
        if_data_n = (state == MC_IF_RD) ? put_byte(if_data, cnt[1:0], mem_din) : if_data;
        cnt_n     = cnt + 3'd1;
        a_n       = (cnt_n < len) ? addr + {29'd0, cnt_n} : mem_a;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= MC_IDLE;
      cnt        <= 3'd0;
      len        <= 3'd0;
      addr       <= 32'd0;
      wdata      <= 32'd0;
      mem_a      <= 32'd0;
      mem_dout   <= 8'd0;
      wr_q       <= 1'b0;
      lsb_done   <= 1'b0;
      if_done    <= 1'b0;
      lsb_r_data <= 32'd0;
      if_data    <= 32'd0;
      if_prio    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      len        <= len_n;
      addr       <= addr_n;
      wdata      <= wdata_n;
      mem_a      <= a_n;
      mem_dout   <= dout_n;
      wr_q       <= wr_n;
      lsb_done   <= lsb_done_n;
      if_done    <= if_done_n;
      lsb_r_data <= lsb_r_n;
      if_data    <= if_data_n;
      if_prio    <= if_prio_n;
    end
  end
endmodule
